pcie_ib_loader: RTL and testbench

//  Inbound stage directly upstream of the crypto engine. It accepts a 128-bit beat stream from the PCIe DMA, tagged per channel.
//  It writes each packet into that channel's slot in the shared packet buffer that the crypto engine reads.
//  It then raises the channel's inbound PCIe-valid flag and holds it until the engine returns its IPSEC-valid acknowledge.
//  8 channels may interleave beats; each channel holds at most one packet (fill -> handoff -> free).

---
 rtl/pcie_ib_loader_pkg.sv | 36 +++
 rtl/pcie_ib_loader_ch.sv | 77 +++++++
 rtl/pcie_ib_loader.sv | 102 ++++++++++
 tb/tb_pcie_ib_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_ib_loader_pkg.sv
// Shared types and constants for the PCIe inbound loader.
// The optional per-channel statistics are enabled by defining PCIE_IB_LOADER_STATS_EN.
package pcie_ib_loader_pkg;

    localparam int CH_NUM     = 8;
    localparam int CH_W       = $clog2(CH_NUM);
    localparam int BUF_BEATS  = 64;
    localparam int BEAT_BYTES = 16;
    localparam int PTR_W      = 7;
    localparam int CNT_W      = 16;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        READY = 2'd3
    } ch_state_e;

    typedef struct packed {
        ch_state_e        state;
        logic [PTR_W-1:0] wr_ptr;
        logic             err;
    } ch_ctx_t;

    // Byte address of beat 'ptr' inside channel slot 'ch'; wraps modulo 2^32.
    function automatic logic [31:0] slot_addr(input logic [31:0]      base,
                                              input logic [CH_W-1:0]  ch,
                                              input logic [PTR_W-1:0] ptr,
                                              input int               buf_beats);
        logic [31:0] stride;
        stride = 32'(buf_beats * BEAT_BYTES);
        return base + (32'(ch) * stride) + (32'(ptr) * 32'(BEAT_BYTES));
    endfunction

endpackage

// File: rtl/pcie_ib_loader_ch.sv
// One channel slot: fill / handoff / free state machine with its write pointer and overflow flag.
module pcie_ib_loader_ch
    import pcie_ib_loader_pkg::*;
#(
    parameter int PTR_LIMIT = BUF_BEATS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             last,
    input  logic             ack,
    output ch_state_e        state,
    output logic [PTR_W-1:0] ptr,
    output logic             err,
    output logic             valid
);

    ch_ctx_t ctx_r;
    ch_ctx_t ctx_nxt_s;

    // Channel context register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctx_r.state  <= IDLE;
            ctx_r.wr_ptr <= 7'd0;
            ctx_r.err    <= 1'b0;
        end else begin
            ctx_r <= ctx_nxt_s;
        end
    end

    // Next-state logic; a beat arriving on a full slot only marks the overflow.
    always_comb begin
        ctx_nxt_s = ctx_r;
        case (ctx_r.state)
            IDLE, FILL: begin
                if (accept) begin
                    if (ctx_r.wr_ptr == PTR_W'(PTR_LIMIT)) begin
                        ctx_nxt_s.err = 1'b1;
                    end else begin
                        ctx_nxt_s.wr_ptr = ctx_r.wr_ptr + 7'd1;
                    end
                    if (last) begin
                        ctx_nxt_s.state = DONE;
                    end else begin
                        ctx_nxt_s.state = FILL;
                    end
                end else begin
                    ctx_nxt_s.state = ctx_r.state;
                end
            end
            DONE: begin
                ctx_nxt_s.state = READY;
            end
            READY: begin
                if (ack) begin
                    ctx_nxt_s.state  = IDLE;
                    ctx_nxt_s.wr_ptr = 7'd0;
                    ctx_nxt_s.err    = 1'b0;
                end else begin
                    ctx_nxt_s.state = READY;
                end
            end
            default: begin
                ctx_nxt_s.state  = IDLE;
                ctx_nxt_s.wr_ptr = 7'd0;
                ctx_nxt_s.err    = 1'b0;
            end
        endcase
    end

    assign state = ctx_r.state;
    assign ptr   = ctx_r.wr_ptr;
    assign err   = ctx_r.err;
    assign valid = (ctx_r.state == READY);

endmodule

// File: rtl/pcie_ib_loader.sv
// Inbound PCIe beat loader feeding per-channel slots of the crypto packet buffer.
// Define PCIE_IB_LOADER_STATS_EN to add per-channel release and overflow counters.
module pcie_ib_loader
    import pcie_ib_loader_pkg::*;
#(
    parameter int          SLOT_BEATS = BUF_BEATS,
    parameter logic [31:0] SLOT_BASE  = BASE_ADDR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [CH_W-1:0]             s_chan,
    input  logic [127:0]                s_data,
    input  logic                        s_last,
    output logic                        mem_wr_en,
    output logic [31:0]                 mem_wr_addr,
    output logic [127:0]                mem_wr_data,
    output logic [CH_NUM-1:0]           ib_pcie_valid,
    input  logic [CH_NUM-1:0]           ib_ipsec_valid,
    output logic [CH_NUM-1:0][PTR_W-1:0] ib_len,
    output logic [CH_NUM-1:0]           ib_err
`ifdef PCIE_IB_LOADER_STATS_EN
    ,
    output logic [CH_NUM-1:0][CNT_W-1:0] pkt_cnt,
    output logic [CH_NUM-1:0][CNT_W-1:0] ovf_cnt
`endif
);

    ch_state_e                  state_s [CH_NUM];
    logic [CH_NUM-1:0][PTR_W-1:0] ptr_s;
    logic [CH_NUM-1:0]          err_s;
    logic [CH_NUM-1:0]          valid_s;
    logic [CH_NUM-1:0]          accept_s;
    ch_state_e                  sel_state_s;
    logic [PTR_W-1:0]           sel_ptr_s;
    logic                       beat_acc_s;
    logic                       wr_ok_s;

    assign sel_state_s = state_s[s_chan];
    assign sel_ptr_s   = ptr_s[s_chan];
    assign s_ready     = !rst && ((sel_state_s == IDLE) || (sel_state_s == FILL));
    assign beat_acc_s  = s_valid && s_ready;
    // Beats landing on a saturated pointer are swallowed, not written.
    assign wr_ok_s     = beat_acc_s && (sel_ptr_s != PTR_W'(SLOT_BEATS));

    genvar g;
    generate
        for (g = 0; g < CH_NUM; g++) begin : g_ch
            assign accept_s[g] = beat_acc_s && (s_chan == CH_W'(g));

            pcie_ib_loader_ch #(
                .PTR_LIMIT (SLOT_BEATS)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .accept (accept_s[g]),
                .last   (s_last),
                .ack    (ib_ipsec_valid[g]),
                .state  (state_s[g]),
                .ptr    (ptr_s[g]),
                .err    (err_s[g]),
                .valid  (valid_s[g])
            );

            assign ib_pcie_valid[g] = valid_s[g];
            assign ib_len[g]        = valid_s[g] ? ptr_s[g] : 7'd0;
            assign ib_err[g]        = valid_s[g] && err_s[g];

`ifdef PCIE_IB_LOADER_STATS_EN
            // Release and overflow-release counters for this channel.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pkt_cnt[g] <= 16'd0;
                    ovf_cnt[g] <= 16'd0;
                end else if (valid_s[g] && ib_ipsec_valid[g]) begin
                    pkt_cnt[g] <= pkt_cnt[g] + 16'd1;
                    if (err_s[g]) begin
                        ovf_cnt[g] <= ovf_cnt[g] + 16'd1;
                    end
                end
            end
`endif
        end
    endgenerate

    // Registered buffer write port, one cycle behind the accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= 32'h0000_0000;
            mem_wr_data <= 128'd0;
        end else begin
            mem_wr_en <= wr_ok_s;
            if (wr_ok_s) begin
                mem_wr_addr <= slot_addr(SLOT_BASE, s_chan, sel_ptr_s, SLOT_BEATS);
                mem_wr_data <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_pcie_ib_loader.sv
// Directed self-checking bench for pcie_ib_loader with a write scoreboard.
module tb_pcie_ib_loader;
    import pcie_ib_loader_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         s_valid;
    logic                         s_ready;
    logic [2:0]                   s_chan;
    logic [127:0]                 s_data;
    logic                         s_last;
    logic                         mem_wr_en;
    logic [31:0]                  mem_wr_addr;
    logic [127:0]                 mem_wr_data;
    logic [7:0]                   ib_pcie_valid;
    logic [7:0]                   ib_ipsec_valid;
    logic [7:0][6:0]              ib_len;
    logic [7:0]                   ib_err;
`ifdef PCIE_IB_LOADER_STATS_EN
    logic [7:0][15:0]             pkt_cnt;
    logic [7:0][15:0]             ovf_cnt;
`endif

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    pcie_ib_loader dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_chan         (s_chan),
        .s_data         (s_data),
        .s_last         (s_last),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .ib_pcie_valid  (ib_pcie_valid),
        .ib_ipsec_valid (ib_ipsec_valid),
        .ib_len         (ib_len),
        .ib_err         (ib_err)
`ifdef PCIE_IB_LOADER_STATS_EN
        ,
        .pkt_cnt        (pkt_cnt),
        .ovf_cnt        (ovf_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat for a cycle; expected write pushed when the slot has room.
    task automatic beat(input int ch, input logic [127:0] d, input logic last,
                        input logic exp_rdy, input logic exp_wr, input logic [31:0] exp_addr);
        wr_t w;
        s_valid = 1'b1;
        s_chan  = 3'(ch);
        s_data  = d;
        s_last  = last;
        #1;
        check("s_ready", 32'(s_ready), 32'(exp_rdy));
        if (exp_wr) begin
            w.addr = exp_addr;
            w.data = d;
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic ack(input logic [7:0] mask);
        ib_ipsec_valid = mask;
        tick();
        ib_ipsec_valid = 8'h00;
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr %0h expected no write", mem_wr_addr);
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                n_tests++;
                assert ({mem_wr_addr, mem_wr_data} === {e.addr, e.data}) else begin
                    n_fail++;
                    $error("FAIL write: observed %0h/%0h expected %0h/%0h",
                           mem_wr_addr, mem_wr_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_chan = 3'd0; s_data = 128'd0; s_last = 1'b0;
        ib_ipsec_valid = 8'h00;
        repeat (3) tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_wr_addr", mem_wr_addr, 32'd0);
        check("rst_valid", 32'(ib_pcie_valid), 32'd0);
        check("rst_len", 32'(ib_len == 56'd0), 32'd1);
        check("rst_err", 32'(ib_err), 32'd0);
        rst = 1'b0;
        tick();

        // 1: ch0, 4 beats
        for (int i = 0; i < 4; i++) beat(0, 128'(i), i == 3, 1'b1, 1'b1, 32'(i * 16));
        check("t1_valid_t1", 32'(ib_pcie_valid[0]), 32'd0);
        tick();
        check("t1_valid_t2", 32'(ib_pcie_valid[0]), 32'd1);
        check("t1_len", 32'(ib_len[0]), 32'd4);
        check("t1_err", 32'(ib_err[0]), 32'd0);
        repeat (4) tick();
        check("t1_valid_hold", 32'(ib_pcie_valid[0]), 32'd1);
        ack(8'h01);
        check("t1_valid_drop", 32'(ib_pcie_valid[0]), 32'd0);
        check("t1_s_ready_free", 32'(s_ready), 32'd1);

        // 2: interleave ch2/ch5
        for (int i = 0; i < 3; i++) begin
            beat(2, 128'(32'h200 + i), i == 2, 1'b1, 1'b1, 32'h800 + 32'(i * 16));
            beat(5, 128'(32'h500 + i), i == 2, 1'b1, 1'b1, 32'h1400 + 32'(i * 16));
        end
        tick();
        check("t2_valid", 32'(ib_pcie_valid), 32'h24);
        check("t2_len2", 32'(ib_len[2]), 32'd3);
        check("t2_len5", 32'(ib_len[5]), 32'd3);
        ack(8'h24);
        check("t2_release", 32'(ib_pcie_valid), 32'h00);

        // 3: back-pressure on a READY channel
        beat(1, 128'h11, 1'b1, 1'b1, 1'b1, 32'h400);
        tick();
        check("t3_valid", 32'(ib_pcie_valid[1]), 32'd1);
        beat(1, 128'h12, 1'b1, 1'b0, 1'b0, 32'h0);
        check("t3_no_write", 32'(mem_wr_en), 32'd0);
        ack(8'h02);
        beat(1, 128'h13, 1'b1, 1'b1, 1'b1, 32'h400);

        // 4: ch3 overflow, 66 beats
        for (int i = 0; i < 66; i++)
            beat(3, 128'(32'h3000 + i), i == 65, 1'b1, i < 64, 32'hC00 + 32'(i * 16));
        check("t4_valid_t1", 32'(ib_pcie_valid[3]), 32'd0);
        tick();
        check("t4_valid", 32'(ib_pcie_valid[3]), 32'd1);
        check("t4_len", 32'(ib_len[3]), 32'd64);
        check("t4_err", 32'(ib_err[3]), 32'd1);
        ack(8'h08);
        check("t4_release", 32'(ib_pcie_valid[3]), 32'd0);
        check("t4_err_clear", 32'(ib_err[3]), 32'd0);

        // 5: reset in the middle of a ch4 fill
        beat(4, 128'h40, 1'b0, 1'b1, 1'b1, 32'h1000);
        beat(4, 128'h41, 1'b0, 1'b1, 1'b1, 32'h1010);
        rst = 1'b1;
        tick();
        check("t5_s_ready", 32'(s_ready), 32'd0);
        check("t5_wr_en", 32'(mem_wr_en), 32'd0);
        check("t5_wr_addr", mem_wr_addr, 32'd0);
        check("t5_wr_data", 32'(mem_wr_data == 128'd0), 32'd1);
        check("t5_valid", 32'(ib_pcie_valid), 32'd0);
        check("t5_len", 32'(ib_len == 56'd0), 32'd1);
        rst = 1'b0;
        tick();
        beat(4, 128'h4A, 1'b1, 1'b1, 1'b1, 32'h1000);
        tick();
        check("t5_valid4", 32'(ib_pcie_valid[4]), 32'd1);
        check("t5_len4", 32'(ib_len[4]), 32'd1);
        ack(8'h10);

`ifdef PCIE_IB_LOADER_STATS_EN
        // 6: statistics on ch0
        for (int p = 0; p < 3; p++) begin
            int nb;
            nb = (p == 1) ? 65 : 1;
            for (int i = 0; i < nb; i++)
                beat(0, 128'(32'h6000 + i), i == nb - 1, 1'b1, i < 64, 32'(i * 16));
            tick();
            ack(8'h01);
        end
        check("t6_pkt_cnt", 32'(pkt_cnt[0]), 32'd3);
        check("t6_ovf_cnt", 32'(ovf_cnt[0]), 32'd1);
`endif

        repeat (3) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
